// File: rtl/goertzel_bin_sched.sv
// Sequencer that time-shares one Goertzel iteration datapath across NF bins.
// Each accepted sample is issued to the datapath once per bin, in bin order.
module goertzel_bin_sched #(
  parameter int NF = 11,
  parameter int NS = 1000,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          coef_valid,
  input  logic          smp_valid,
  output logic          smp_ready,
  input  logic [DW-1:0] smp_data,
  output logic          dp_req,
  input  logic          dp_ack,
  output logic [7:0]    dp_bin,
  output logic [DW-1:0] dp_smp,
  output logic          dp_first,
  output logic          dp_last,
  output logic [15:0]   smp_cnt,
  output logic          busy,
  output logic          done
);

  if (NF < 1 || NF > 255) begin : g_bad_nf
    $error("goertzel_bin_sched: NF must be in 1..255");
  end
  if (NS < 2 || NS > 65535) begin : g_bad_ns
    $error("goertzel_bin_sched: NS must be in 2..65535");
  end

  localparam logic [7:0]  LAST_BIN = 8'(NF - 1);
  localparam logic [15:0] LAST_SMP = 16'(NS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COEF,
    WAIT_SMP,
    ISSUE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      dp_bin_q, dp_bin_d;
  logic [DW-1:0]   dp_smp_q, dp_smp_d;
  logic [15:0]     smp_cnt_q, smp_cnt_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    dp_bin_d  = dp_bin_q;
    dp_smp_d  = dp_smp_q;
    smp_cnt_d = smp_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = coef_valid ? WAIT_SMP : WAIT_COEF;
          smp_cnt_d = '0;
          dp_bin_d  = '0;
        end
      end
      WAIT_COEF: begin
        if (abort)           state_d = IDLE;
        else if (coef_valid) state_d = WAIT_SMP;
      end
      WAIT_SMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (smp_valid) begin
          dp_smp_d = smp_data;
          dp_bin_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dp_ack) begin
          if (dp_bin_q != LAST_BIN) begin
            dp_bin_d = dp_bin_q + 8'd1;
          end else if (smp_cnt_q != LAST_SMP) begin
            smp_cnt_d = smp_cnt_q + 16'd1;
            state_d   = WAIT_SMP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      dp_bin_q  <= '0;
      dp_smp_q  <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dp_bin_q  <= dp_bin_d;
      dp_smp_q  <= dp_smp_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Handshake outputs are pure decodes of the state register, so they change only on clock edges.
  assign smp_ready = (state_q == WAIT_SMP);
  assign dp_req    = (state_q == ISSUE);
  assign dp_first  = dp_req && (smp_cnt_q == 16'd0);
  assign dp_last   = dp_req && (smp_cnt_q == LAST_SMP);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dp_bin    = dp_bin_q;
  assign dp_smp    = dp_smp_q;
  assign smp_cnt   = smp_cnt_q;

endmodule
